// File: rtl/spi_burst_ctrl_pkg.sv
// Shared types and constants for the SPI burst sequencer.
package spi_burst_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO used for both TX and RX buffering.
module spi_byte_fifo
    import spi_burst_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Pops on empty are ignored; a push while full is only taken alongside a pop.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte SPI burst sequencer: frames a burst with cs_n, feeds TX bytes to
// spi_master one at a time and buffers the received bytes for the consumer.
module spi_burst_ctrl
    import spi_burst_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LEN_W    = 8,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              cs_n,
    output logic              m_start,
    output logic [BYTE_W-1:0] m_mosi_in,
    input  logic              m_done,
    input  logic [BYTE_W-1:0] m_miso_out
);

    localparam int unsigned T_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [TW-1:0]     timer_q;
    logic              cs_n_q;
    logic [BYTE_W-1:0] mosi_q;

    logic              cmd_fire;
    logic              can_go;
    logic              setup_done;
    logic              hold_done;
    logic              last_byte;

    logic              tx_push;
    logic              tx_pop;
    logic [BYTE_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_push;
    logic              rx_full;
    logic              rx_empty;

    assign cmd_fire   = cmd_valid & cmd_ready;
    assign can_go     = ~tx_empty & ~rx_full;
    assign setup_done = (timer_q == TW'(CS_SETUP - 1));
    assign hold_done  = (timer_q == TW'(CS_HOLD - 1));
    assign last_byte  = (rem_q == LEN_W'(1));
    assign cs_n       = cs_n_q;
    assign tx_ready   = ~tx_full;
    assign rx_valid   = ~rx_empty;

    spi_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (m_miso_out),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: TX underrun and RX backpressure only stall in LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_fire && cmd_len != '0) state_d = ST_SETUP;
            ST_SETUP: if (setup_done) state_d = ST_LOAD;
            ST_LOAD:  if (can_go) state_d = ST_WAIT;
            ST_WAIT:  if (m_done) state_d = last_byte ? ST_HOLD : ST_LOAD;
            ST_HOLD:  if (hold_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Burst datapath: remaining count, cs timing, chip select and held MOSI byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q   <= '0;
            timer_q <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire && cmd_len != '0) begin
                        rem_q   <= cmd_len;
                        timer_q <= '0;
                        cs_n_q  <= 1'b0;
                    end
                end
                ST_SETUP: timer_q <= timer_q + TW'(1);
                ST_LOAD: begin
                    if (can_go) begin
                        mosi_q <= tx_head;
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (last_byte) begin
                            timer_q <= '0;
                        end
                    end
                end
                ST_HOLD: begin
                    timer_q <= timer_q + TW'(1);
                    if (hold_done) begin
                        cs_n_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs and FIFO strobes.
    // m_mosi_in bypasses the TX head during the m_start cycle so the byte is
    // valid together with the start pulse, then the registered copy holds it.
    always_comb begin
        m_start   = (state_q == ST_LOAD) & can_go;
        m_mosi_in = m_start ? tx_head : mosi_q;
        busy      = (state_q != ST_IDLE);
        cmd_ready = (state_q == ST_IDLE);
        tx_push   = tx_valid & ~tx_full;
        tx_pop    = m_start;
        rx_push   = (state_q == ST_WAIT) & m_done;
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Self-checking bench for spi_burst_ctrl with a behavioural spi_master stub.
module tb_spi_burst_ctrl;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned CS_SETUP = 2;
    localparam int unsigned CS_HOLD  = 2;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             cs_n;
    logic             m_start;
    logic [7:0]       m_mosi_in;
    logic             m_done;
    logic [7:0]       m_miso_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] push_q[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];

    int  n_start = 0;
    int  n_done = 0;
    int  cs_fall = 0;
    int  cs_rise_cyc = 0;
    int  last_start_cyc = 0;
    int  last_done_cyc = 0;
    int  last_push_cyc = 0;
    bit  t3_mode = 0;
    bit  force_done = 0;
    bit  rx_en = 1;

    spi_burst_ctrl #(
        .DEPTH    (DEPTH),
        .LEN_W    (LEN_W),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .cs_n       (cs_n),
        .m_start    (m_start),
        .m_mosi_in  (m_mosi_in),
        .m_done     (m_done),
        .m_miso_out (m_miso_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // TX driver: feeds queued bytes when tx_ready, recording scoreboard expectations.
    initial begin
        logic [7:0] b;
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (rst && push_q.size() > 0 && tx_ready) begin
                b = push_q.pop_front();
                tx_data  = b;
                tx_valid = 1'b1;
                exp_mosi.push_back(b);
                exp_rx.push_back(~b);
                last_push_cyc = cyc;
            end else begin
                tx_valid = 1'b0;
            end
        end
    end

    // RX consumer: pops when enabled and compares against the scoreboard.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            rx_ready = rx_en;
            if (rst && rx_valid && rx_ready) begin
                if (exp_rx.size() > 0)
                    check_eq("rx_byte", rx_data, exp_rx.pop_front());
                else
                    check_eq("rx_pop_without_expectation", exp_rx.size(), 1);
            end
        end
    end

    // spi_master stub plus cs_n edge monitor.
    initial begin
        int         cnt;
        int         lat;
        logic [7:0] mosi_rec;
        bit         prev_cs;
        cnt = 0;
        mosi_rec = '0;
        prev_cs = 1'b1;
        m_done = 1'b0;
        m_miso_out = '0;
        forever begin
            @(negedge clk);
            if (prev_cs && !cs_n) cs_fall++;
            if (!prev_cs && cs_n) cs_rise_cyc = cyc;
            prev_cs = cs_n;
            m_done = 1'b0;
            if (!rst) begin
                cnt = 0;
                force_done = 0;
            end else begin
                if (force_done) begin
                    m_done = 1'b1;
                    m_miso_out = 8'h99;
                    force_done = 0;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        check_eq("mosi_hold", m_mosi_in, mosi_rec);
                        m_done = 1'b1;
                        m_miso_out = ~mosi_rec;
                        n_done++;
                        last_done_cyc = cyc;
                    end
                end
                if (m_start) begin
                    n_start++;
                    last_start_cyc = cyc;
                    mosi_rec = m_mosi_in;
                    cnt = 20;
                    check_eq("cs_low_at_start", cs_n, 0);
                    if (exp_mosi.size() > 0)
                        check_eq("mosi_byte", m_mosi_in, exp_mosi.pop_front());
                    else
                        check_eq("start_without_tx_byte", exp_mosi.size(), 1);
                    if (t3_mode) begin
                        lat = cyc - last_push_cyc;
                        check_eq("t3_push_to_start_1_2", (lat >= 1 && lat <= 2), 1);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input logic [LEN_W-1:0] len, output int hcyc);
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        check_eq("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = len;
        hcyc      = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_eq(tag, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int h;
        int s0;
        int f0;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_len = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_m_start", m_start, 0);
        check_eq("rst_m_mosi_in", m_mosi_in, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_tx_ready", tx_ready, 1);

        // T1: single byte
        s0 = n_start; f0 = cs_fall;
        push_q.push_back(8'h5A);
        repeat (3) @(negedge clk);
        do_cmd(1, h);
        check_eq("t1_cs_low", cs_n, 0);
        wait_idle("t1_idle");
        check_eq("t1_starts", n_start - s0, 1);
        check_eq("t1_start_latency", last_start_cyc - h, CS_SETUP + 1);
        check_eq("t1_cs_hold", cs_rise_cyc - last_done_cyc, CS_HOLD + 1);
        check_eq("t1_cs_falls", cs_fall - f0, 1);
        check_eq("t1_rx_drained", exp_rx.size(), 0);

        // T2: four-byte burst
        s0 = n_start; f0 = cs_fall;
        for (int i = 1; i <= 4; i++) push_q.push_back(8'(i));
        repeat (6) @(negedge clk);
        do_cmd(4, h);
        wait_idle("t2_idle");
        check_eq("t2_starts", n_start - s0, 4);
        check_eq("t2_cs_falls", cs_fall - f0, 1);
        check_eq("t2_rx_drained", exp_rx.size(), 0);

        // T3: TX underrun stalls the burst
        s0 = n_start; f0 = cs_fall;
        t3_mode = 1;
        do_cmd(3, h);
        repeat (20) @(negedge clk);
        check_eq("t3_stall_cs_low", cs_n, 0);
        check_eq("t3_stall_busy", busy, 1);
        check_eq("t3_stall_no_start", n_start - s0, 0);
        for (int i = 0; i < 3; i++) begin
            push_q.push_back(8'h30 + 8'(i));
            repeat (100) @(negedge clk);
        end
        wait_idle("t3_idle");
        t3_mode = 0;
        check_eq("t3_starts", n_start - s0, 3);
        check_eq("t3_cs_falls", cs_fall - f0, 1);
        check_eq("t3_rx_drained", exp_rx.size(), 0);

        // T4: RX backpressure
        s0 = n_start; f0 = cs_fall;
        rx_en = 0;
        for (int i = 0; i < 10; i++) push_q.push_back(8'h80 + 8'(i * 7));
        do_cmd(10, h);
        for (int i = 0; i < 3000; i++) begin
            if (n_start - s0 >= 8 && n_done >= s0 + 8) break;
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check_eq("t4_stall_starts", n_start - s0, 8);
        check_eq("t4_stall_rx_valid", rx_valid, 1);
        check_eq("t4_stall_cs_low", cs_n, 0);
        check_eq("t4_stall_busy", busy, 1);
        rx_en = 1;
        wait_idle("t4_idle");
        check_eq("t4_starts", n_start - s0, 10);
        check_eq("t4_cs_falls", cs_fall - f0, 1);
        check_eq("t4_rx_drained", exp_rx.size(), 0);

        // T5: reset during WAIT of byte 2
        s0 = n_start;
        for (int i = 0; i < 3; i++) push_q.push_back(8'h11 * 8'(i + 1));
        do_cmd(3, h);
        for (int i = 0; i < 1000; i++) begin
            if (n_start - s0 >= 2) break;
            @(negedge clk);
        end
        check_eq("t5_reached_byte2", n_start - s0, 2);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        push_q.delete();
        exp_mosi.delete();
        exp_rx.delete();
        #1;
        check_eq("t5_rst_cs_n", cs_n, 1);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_rx_valid", rx_valid, 0);
        check_eq("t5_rst_tx_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        s0 = n_start; f0 = cs_fall;
        push_q.push_back(8'h3C);
        repeat (3) @(negedge clk);
        do_cmd(1, h);
        wait_idle("t5_idle");
        check_eq("t5_starts", n_start - s0, 1);
        check_eq("t5_cs_falls", cs_fall - f0, 1);
        check_eq("t5_rx_drained", exp_rx.size(), 0);

        // T6: zero-length command and spurious m_done
        s0 = n_start; f0 = cs_fall;
        do_cmd(0, h);
        repeat (5) @(negedge clk);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_cmd_ready", cmd_ready, 1);
        force_done = 1;
        repeat (5) @(negedge clk);
        check_eq("t6_rx_valid", rx_valid, 0);
        check_eq("t6_starts", n_start - s0, 0);
        check_eq("t6_cs_falls", cs_fall - f0, 0);
        check_eq("t6_cs_n", cs_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
